// File: rtl/frame_sanitizer.sv
// Frame sanitizer: forwards header/data/footer frames from the mixer stream,
// drops orphan words and closes frames whose footer is missing.
module frame_sanitizer #(
  parameter int          DATA_WIDTH    = 64,
  parameter logic [15:0] HEADER_ID     = 16'hAAAA,
  parameter logic [15:0] FOOTER_ID     = 16'h5555,
  parameter logic [15:0] ERR_FOOTER_ID = 16'hEEEE,
  parameter int          CNT_WIDTH     = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [DATA_WIDTH-1:0] DIN,
  input  logic                  iVALID,
  output logic                  oREADY,
  output logic [DATA_WIDTH-1:0] DOUT,
  output logic                  oVALID,
  input  logic                  iREADY,
  output logic [CNT_WIDTH-1:0]  FRAME_CNT,
  output logic [CNT_WIDTH-1:0]  HEADER_LOST_CNT,
  output logic [CNT_WIDTH-1:0]  FOOTER_LOST_CNT
);

  typedef enum logic [1:0] {
    ST_HDR = 2'd0,
    ST_DAT = 2'd1,
    ST_FTR = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] ERR_WORD = {{(DATA_WIDTH-16){1'b0}}, ERR_FOOTER_ID};

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  state_t                  state_r, state_s;
  logic [11:0]             rem_r, rem_s;
  logic [DATA_WIDTH-1:0]   dout_r, dout_s;
  logic                    valid_r, valid_s;
  logic [CNT_WIDTH-1:0]    frame_cnt_r, hl_cnt_r, fl_cnt_r;
  logic                    inc_frame_s, inc_hl_s, inc_fl_s;
  logic                    hdr_ok_s, ftr_ok_s, out_free_s, synth_s, accept_s;
  logic [11:0]             len_s;

  assign hdr_ok_s   = (DIN[63:48] == HEADER_ID);
  assign ftr_ok_s   = (DIN[15:0] == FOOTER_ID);
  assign len_s      = DIN[11:0];
  assign out_free_s = !valid_r || iREADY;
  // A non-footer word in FTR is held back while the synthetic footer goes out.
  assign synth_s    = (state_r == ST_FTR) && iVALID && !ftr_ok_s;
  assign oREADY     = out_free_s && !synth_s;
  assign accept_s   = iVALID && oREADY;

  assign DOUT            = dout_r;
  assign oVALID          = valid_r;
  assign FRAME_CNT       = frame_cnt_r;
  assign HEADER_LOST_CNT = hl_cnt_r;
  assign FOOTER_LOST_CNT = fl_cnt_r;

  // Next-state, output-word and counter-increment decode.
  always_comb begin
    state_s     = state_r;
    rem_s       = rem_r;
    dout_s      = dout_r;
    valid_s     = valid_r && !iREADY;
    inc_frame_s = 1'b0;
    inc_hl_s    = 1'b0;
    inc_fl_s    = 1'b0;
    case (state_r)
      ST_HDR: begin
        if (accept_s && hdr_ok_s) begin
          dout_s  = DIN;
          valid_s = 1'b1;
          rem_s   = len_s;
          state_s = (len_s != 12'd0) ? ST_DAT : ST_FTR;
        end else begin
          inc_hl_s = accept_s;
        end
      end
      ST_DAT: begin
        if (accept_s) begin
          dout_s  = DIN;
          valid_s = 1'b1;
          rem_s   = rem_r - 12'd1;
          state_s = (rem_r == 12'd1) ? ST_FTR : ST_DAT;
        end else begin
          state_s = ST_DAT;
        end
      end
      ST_FTR: begin
        if (iVALID && out_free_s) begin
          valid_s     = 1'b1;
          state_s     = ST_HDR;
          dout_s      = ftr_ok_s ? DIN : ERR_WORD;
          inc_frame_s = ftr_ok_s;
          inc_fl_s    = !ftr_ok_s;
        end else begin
          state_s = ST_FTR;
        end
      end
      default: begin
        state_s = ST_HDR;
      end
    endcase
  end

  // State, output register and saturating status counters.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r     <= ST_HDR;
      rem_r       <= 12'd0;
      dout_r      <= {DATA_WIDTH{1'b0}};
      valid_r     <= 1'b0;
      frame_cnt_r <= {CNT_WIDTH{1'b0}};
      hl_cnt_r    <= {CNT_WIDTH{1'b0}};
      fl_cnt_r    <= {CNT_WIDTH{1'b0}};
    end else begin
      state_r <= state_s;
      rem_r   <= rem_s;
      dout_r  <= dout_s;
      valid_r <= valid_s;
      if (inc_frame_s) frame_cnt_r <= sat_inc(frame_cnt_r);
      if (inc_hl_s)    hl_cnt_r    <= sat_inc(hl_cnt_r);
      if (inc_fl_s)    fl_cnt_r    <= sat_inc(fl_cnt_r);
    end
  end

endmodule

// File: tb/tb_frame_sanitizer.sv
// Bench for frame_sanitizer: directed scenarios plus random frames checked
// against a word-sequence reference model.
module tb_frame_sanitizer;

  localparam int CW     = 4;
  localparam int CW_MAX = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic [63:0]   DIN = 64'd0;
  logic          iVALID = 1'b0;
  logic          oREADY;
  logic [63:0]   DOUT;
  logic          oVALID;
  logic          iREADY = 1'b1;
  logic [CW-1:0] FRAME_CNT, HEADER_LOST_CNT, FOOTER_LOST_CNT;

  frame_sanitizer #(.CNT_WIDTH(CW)) dut (
    .CLK(CLK), .RESET(RESET), .DIN(DIN), .iVALID(iVALID), .oREADY(oREADY),
    .DOUT(DOUT), .oVALID(oVALID), .iREADY(iREADY),
    .FRAME_CNT(FRAME_CNT), .HEADER_LOST_CNT(HEADER_LOST_CNT),
    .FOOTER_LOST_CNT(FOOTER_LOST_CNT)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: consumes the offered word sequence, yields expected output words.
  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];
  int m_state = 0;  // 0 expect header, 1 in data, 2 expect footer
  int m_rem = 0, m_fc = 0, m_hl = 0, m_fl = 0;

  function automatic int sat(input int v);
    return (v >= CW_MAX) ? CW_MAX : v + 1;
  endfunction

  task automatic model_word(input logic [63:0] w);
    if (m_state == 2) begin
      if (w[15:0] == 16'h5555) begin
        exp_q.push_back(w);
        m_fc = sat(m_fc);
        m_state = 0;
        return;
      end
      exp_q.push_back(64'h0000_0000_0000_EEEE);
      m_fl = sat(m_fl);
      m_state = 0;
    end
    if (m_state == 1) begin
      exp_q.push_back(w);
      m_rem--;
      if (m_rem == 0) m_state = 2;
    end else if (w[63:48] == 16'hAAAA) begin
      exp_q.push_back(w);
      m_rem = int'(w[11:0]);
      m_state = (m_rem == 0) ? 2 : 1;
    end else begin
      m_hl = sat(m_hl);
    end
  endtask

  logic rand_ready = 1'b0;
  always @(negedge CLK) if (rand_ready) iREADY = ($urandom_range(0, 3) != 0);

  // Output monitor: collects transfers and checks the held word stays put.
  logic        hold_prev = 1'b0;
  logic [63:0] dout_prev = 64'd0;
  always @(negedge CLK) begin
    #2;
    if (RESET) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", 64'(oVALID), 64'd1);
        check("hold_dout", DOUT, dout_prev);
      end
      if (oVALID && iREADY) got_q.push_back(DOUT);
      hold_prev = oVALID && !iREADY;
      dout_prev = DOUT;
    end
  end

  task automatic send(input logic [63:0] w, output int stalls);
    bit took;
    int guard;
    model_word(w);
    stalls = 0;
    took = 1'b0;
    guard = 0;
    while (!took && guard < 2000) begin
      @(negedge CLK);
      DIN = w;
      iVALID = 1'b1;
      #1;
      took = oREADY;
      if (!took) stalls++;
      @(posedge CLK);
      guard++;
    end
    #1;
    iVALID = 1'b0;
    check("send_accept", 64'(took), 64'd1);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    iVALID = 1'b0;
    #1;
    check("rst_valid", 64'(oVALID), 64'd0);
    check("rst_dout", DOUT, 64'd0);
    check("rst_cnts", 64'({FRAME_CNT, HEADER_LOST_CNT, FOOTER_LOST_CNT}), 64'd0);
    @(negedge CLK);
    RESET = 1'b0;
    m_state = 0; m_rem = 0; m_fc = 0; m_hl = 0; m_fl = 0;
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic drain_compare(input string tag);
    int n = 0;
    while (got_q.size() < exp_q.size() && n < 5000) begin
      @(negedge CLK);
      n++;
    end
    repeat (3) @(negedge CLK);
    #3;
    check({tag, "_nwords"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check({tag, "_word"}, got_q[i], exp_q[i]);
    check({tag, "_frame_cnt"}, 64'(FRAME_CNT), 64'(m_fc));
    check({tag, "_hl_cnt"}, 64'(HEADER_LOST_CNT), 64'(m_hl));
    check({tag, "_fl_cnt"}, 64'(FOOTER_LOST_CNT), 64'(m_fl));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int kind, len;
    logic [63:0] w;
    logic [63:0] t1[6];

    // Good frame, len=4, one-cycle latency each word
    do_reset();
    t1[0] = 64'hAAAA_0000_0010_0004;
    for (int i = 1; i <= 4; i++) t1[i] = 64'hFFFF_FFFF_FFFF_FFFF;
    t1[5] = 64'h1234_0000_0000_5555;
    for (int i = 0; i < 6; i++) begin
      send(t1[i], s);
      check("t1_latency_valid", 64'(oVALID), 64'd1);
      check("t1_latency_dout", DOUT, t1[i]);
      check("t1_no_stall", 64'(s), 64'd0);
    end
    drain_compare("t1");
    check("t1_frame_one", 64'(FRAME_CNT), 64'd1);

    // Orphan words ahead of a good frame
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send(64'hABCD_0000_0000_0000 | 64'(i), s);
      check("t2_orphan_dropped", 64'(oVALID), 64'd0);
    end
    send(64'hAAAA_0000_0000_0002, s);
    send(64'h0000_0000_0000_0011, s);
    send(64'h0000_0000_0000_0022, s);
    send(64'h0000_0000_0000_5555, s);
    drain_compare("t2");
    check("t2_hl_three", 64'(HEADER_LOST_CNT), 64'd3);

    // Missing footer: bad word stalls once then counts as header lost
    do_reset();
    send(64'hAAAA_0000_0000_0002, s);
    send(64'h1111_1111_1111_1111, s);
    send(64'h2222_2222_2222_2222, s);
    send(64'h0000_0000_0000_5678, s);
    check("t3_stall_one", 64'(s), 64'd1);
    send(64'hAAAA_0000_0000_0002, s);
    send(64'h3333_3333_3333_3333, s);
    send(64'h4444_4444_4444_4444, s);
    send(64'h9999_0000_0000_5555, s);
    drain_compare("t3");
    check("t3_counts", 64'({FRAME_CNT, HEADER_LOST_CNT, FOOTER_LOST_CNT}), 64'h111);

    // Next header where the footer belongs
    do_reset();
    send(64'hAAAA_0000_0000_0002, s);
    send(64'h5555_5555_5555_5555, s);
    send(64'h6666_6666_6666_6666, s);
    send(64'hAAAA_0000_0000_0001, s);
    check("t4_stall_one", 64'(s), 64'd1);
    check("t4_header_fwd", DOUT, 64'hAAAA_0000_0000_0001);
    send(64'h7777_7777_7777_7777, s);
    send(64'h0000_0000_0000_5555, s);
    drain_compare("t4");
    check("t4_counts", 64'({FRAME_CNT, HEADER_LOST_CNT, FOOTER_LOST_CNT}), 64'h101);

    // Long downstream stall mid-frame, len=160
    do_reset();
    @(negedge CLK);
    iREADY = 1'b0;
    send(64'hAAAA_0000_0000_00A0, s);
    @(negedge CLK);
    DIN = 64'hD000_0000_0000_0000;
    iVALID = 1'b1;
    repeat (200) @(negedge CLK);
    #1;
    check("t5_ready_low", 64'(oREADY), 64'd0);
    check("t5_held_dout", DOUT, 64'hAAAA_0000_0000_00A0);
    iVALID = 1'b0;
    iREADY = 1'b1;
    rand_ready = 1'b1;
    for (int i = 0; i < 160; i++) send(64'hD000_0000_0000_0000 | 64'(i), s);
    send(64'h0000_0000_0000_5555, s);
    drain_compare("t5");
    check("t5_frame_one", 64'(FRAME_CNT), 64'd1);

    // Random frame mix under random backpressure
    do_reset();
    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(0, 3);
      if (kind == 0) begin
        for (int i = 0; i < $urandom_range(1, 3); i++) begin
          w = {$urandom, $urandom};
          if (w[63:48] == 16'hAAAA) w[63:48] = 16'h1111;
          send(w, s);
        end
      end
      len = $urandom_range(0, 5);
      send({16'hAAAA, 32'($urandom), 4'h0, 12'(len)}, s);
      for (int i = 0; i < len; i++) send({$urandom, $urandom}, s);
      if (kind == 1 || kind == 0) begin
        send({16'h0000, $urandom, 16'h5555}, s);
      end else if (kind == 2) begin
        w = {$urandom, $urandom};
        if (w[15:0] == 16'h5555) w[15:0] = 16'h5678;
        send(w, s);
      end
    end
    drain_compare("t6");
    rand_ready = 1'b0;

    // Counter saturation, then reset mid-frame
    do_reset();
    @(negedge CLK);
    iREADY = 1'b1;
    for (int i = 0; i < 20; i++) send(64'hABCD_0000_0000_0000 | 64'(i), s);
    drain_compare("t7");
    check("t7_hl_sat", 64'(HEADER_LOST_CNT), 64'd15);
    send(64'hAAAA_0000_0000_0005, s);
    send(64'h1234_5678_9ABC_DEF0, s);
    do_reset();
    send(64'h0BAD_0000_0000_0001, s);
    send(64'hAAAA_0000_0000_0001, s);
    send(64'h0000_0000_0000_00AB, s);
    send(64'h0000_0000_0000_5555, s);
    drain_compare("t8");
    check("t8_counts", 64'({FRAME_CNT, HEADER_LOST_CNT, FOOTER_LOST_CNT}), 64'h110);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
